load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   RV32I load/store unit feeding the register-file write port (rd_addr/rd_data/wr_en).
//   Takes one decoded memory op: base (rs1), imm, store data (rs2), funct3, rd.
//   Runs a request/grant/response handshake with data memory, then returns aligned,
//   sign/zero-extended load data to the register file as a one-cycle write pulse.
// PARAMETERS
//   XLEN        32  data/address width
//   REG_ADDR_W  5   register index width
// PORTS
//   clk_in          in   1     clock, rising edge
//   rst_in          in   1     reset, asynchronous, active-low
//   req_valid_in    in   1     op valid from execute
//   req_ready_out   out  1     unit idle, can accept an op
//   is_store_in     in   1     1=store, 0=load
//   funct3_in       in   3     access size/sign (RV32I encoding)
//   base_in         in   XLEN  rs1 value
//   offset_in       in   XLEN  sign-extended immediate
//   store_data_in   in   XLEN  rs2 value
//   rd_addr_in      in   5     load destination
//   dmem_req_out    out  1     memory request, held until grant
//   dmem_we_out     out  1     1=write
//   dmem_addr_out   out  XLEN  word-aligned address ([1:0]=0)
//   dmem_wdata_out  out  XLEN  lane-replicated store data
//   dmem_wmask_out  out  4     byte-enable mask
//   dmem_gnt_in     in   1     request accepted this cycle
//   dmem_rvalid_in  in   1     read data valid
//   dmem_rdata_in   in   XLEN  read word
//   rd_addr_out     out  5     to reg file rd_addr_in
//   rd_data_out     out  XLEN  to reg file rd_data
//   wr_en_out       out  1     one-cycle write pulse
//   done_out        out  1     one-cycle op-complete pulse
//   misalign_out    out  1     one-cycle misaligned-access flag
// BEHAVIOUR
//   Reset: all outputs 0 except req_ready_out=1; FSM=IDLE. Async assert mid-op drops
//     dmem_req_out immediately; late rvalid after reset is ignored.
//   Accept: req_valid_in & req_ready_out at edge T; addr=base+offset (mod 2^32), latched.
//   FSM: IDLE -> REQ (T+1, dmem_req_out=1) -> on gnt: store->DONE, load->WAIT
//     -> on rvalid: WB -> IDLE. DONE/WB last one cycle; req_ready_out=1 only in IDLE.
//   Outputs registered: dmem_req/we/addr/wdata/wmask stable while req high without gnt.
//   Min latency: load gnt T+1, rvalid T+2 -> wr_en_out at T+3; store done_out at T+2.
//   done_out pulses in DONE and WB. wr_en_out pulses in WB only if rd_addr!=0.
//   Sizes: 000 byte, 001 half, 010 word; loads 100 LBU, 101 LHU zero-extend; 000/001 sign-extend.
//     Undefined funct3 (011,110,111; store >010) treated as word.
//   Store mask: SB 4'b0001<<a[1:0]; SH 4'b0011<<{a[1],1'b0}; SW 4'b1111;
//     wdata = byte/half replicated across all lanes.
//   Load extract: lane by a[1:0] (byte) / a[1] (half) from dmem_rdata_in captured at rvalid.
//   rvalid before gnt or outside WAIT: ignored. gnt outside REQ: ignored.
// CONFIGURATION
//   MISALIGN_TRAP_EN defined: half with a[0]=1 or word with a[1:0]!=0 makes no memory
//     request; T+1 misalign_out=1, done_out=1, wr_en_out=0; back to IDLE at T+2.
//   Not defined: misalign_out tied 0; low address bits cleared to size alignment, access proceeds.
// STRUCTURE
//   Package riscv_pkg: funct3 constants (F3_LB..F3_LHU, F3_SB..F3_SW), lsu_state_t
//     enum {IDLE,REQ,WAIT,DONE,WB}, XLEN.
//   Sub-module lsu_align (combinational): size/offset -> wmask, wdata replication,
//     load lane select + extend, misalign detect.
// TESTING
//   LW base=0x100,off=4, gnt same cycle, rdata=0xDEADBEEF next -> wr_en T+3, rd_data=0xDEADBEEF.
//   LB addr=0x103, rdata=0x80FF_0000 -> rd_data=0xFFFFFF80; LBU same -> 0x00000080.
//   SB addr=0x202, rs2=0x000000A5 -> wmask=4'b0100, wdata=0xA5A5A5A5, addr=0x200, done T+2.
//   gnt held low 3 cycles -> dmem_req/addr/mask stable, ready=0; LW rd=x0 -> done, no wr_en.
//   LW addr=0x102: with MISALIGN_TRAP_EN misalign_out=1 at T+1, no dmem_req; without -> addr 0x100.
//   rst_in low in WAIT then high, rvalid arrives -> no wr_en, ready=1, all outputs 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I load/store types: funct3 codes,
// LSU state encoding and access-size decode.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    WB
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_t;

  // Undefined encodings fall back to word.
  function automatic lsu_size_t lsu_size(
    input logic       st,
    input logic [2:0] f3
  );
    lsu_size_t sz;
    sz = SZ_W;
    if (st) begin
      case (f3)
        F3_SB:   sz = SZ_B;
        F3_SH:   sz = SZ_H;
        F3_SW:   sz = SZ_W;
        default: sz = SZ_W;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: sz = SZ_B;
        F3_LH, F3_LHU: sz = SZ_H;
        F3_LW:         sz = SZ_W;
        default:       sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/grant/response bus.
// master = LSU, slave = memory.
interface load_store_unit_if #(
  parameter int XLEN = 32
);
  logic            dmem_req_out;
  logic            dmem_we_out;
  logic [XLEN-1:0] dmem_addr_out;
  logic [XLEN-1:0] dmem_wdata_out;
  logic [3:0]      dmem_wmask_out;
  logic            dmem_gnt_in;
  logic            dmem_rvalid_in;
  logic [XLEN-1:0] dmem_rdata_in;

  modport master (
    output dmem_req_out,
    output dmem_we_out,
    output dmem_addr_out,
    output dmem_wdata_out,
    output dmem_wmask_out,
    input  dmem_gnt_in,
    input  dmem_rvalid_in,
    input  dmem_rdata_in
  );

  modport slave (
    input  dmem_req_out,
    input  dmem_we_out,
    input  dmem_addr_out,
    input  dmem_wdata_out,
    input  dmem_wmask_out,
    output dmem_gnt_in,
    output dmem_rvalid_in,
    output dmem_rdata_in
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Byte-lane logic: store mask/replication,
// load lane select + extend, misalign detect.
module lsu_align
  import riscv_pkg::*;
(
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [1:0]      a,
  input  logic [XLEN-1:0] sdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      wmask,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ldata,
  output logic            misal
);

  lsu_size_t   sz;
  logic        uns;
  logic [7:0]  b;
  logic [15:0] h;

  assign sz  = lsu_size(is_store, funct3);
  assign uns = ~is_store & funct3[2];
  assign b   = rdata[{a, 3'b000} +: 8];
  assign h   = a[1] ? rdata[31:16] : rdata[15:0];

  // Lane decode per access size; word is the default.
  always_comb begin
    wmask = 4'b1111;
    wdata = sdata;
    ldata = rdata;
    misal = (a != 2'b00);
    unique case (1'b1)
      (sz == SZ_B): begin
        wmask = 4'b0001 << a;
        wdata = {4{sdata[7:0]}};
        ldata = {{24{~uns & b[7]}}, b};
        misal = 1'b0;
      end
      (sz == SZ_H): begin
        wmask = 4'b0011 << {a[1], 1'b0};
        wdata = {2{sdata[15:0]}};
        ldata = {{16{~uns & h[15]}}, h};
        misal = a[0];
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving the reg-file write port.
// Optional MISALIGN_TRAP_EN: misaligned ops skip memory and flag.
module load_store_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic                  is_store_in,
  input  logic [2:0]            funct3_in,
  input  logic [XLEN-1:0]       base_in,
  input  logic [XLEN-1:0]       offset_in,
  input  logic [XLEN-1:0]       store_data_in,
  input  logic [REG_ADDR_W-1:0] rd_addr_in,
  load_store_unit_if.master     dmem,
  output logic [REG_ADDR_W-1:0] rd_addr_out,
  output logic [XLEN-1:0]       rd_data_out,
  output logic                  wr_en_out,
  output logic                  done_out,
  output logic                  misalign_out
);
  import riscv_pkg::*;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  lsu_state_t state_q, state_d;

  logic                  is_store_q;
  logic [2:0]            f3_q;
  logic [XLEN-1:0]       addr_q;
  logic [XLEN-1:0]       wdata_q;
  logic [XLEN-1:0]       rdata_q;
  logic [3:0]            wmask_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  misal_q;

  logic            idle;
  logic            accept;
  logic            trap;
  logic [XLEN-1:0] addr_n;
  logic            al_st;
  logic [2:0]      al_f3;
  logic [1:0]      al_a;
  logic [3:0]      al_wmask;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_ldata;
  logic            al_misal;

  assign idle   = (state_q == IDLE);
  assign accept = req_valid_in & idle;
  assign addr_n = base_in + offset_in;

  assign al_st = idle ? is_store_in : is_store_q;
  assign al_f3 = idle ? funct3_in : f3_q;
  assign al_a  = idle ? addr_n[1:0] : addr_q[1:0];
  assign trap  = TRAP_EN & al_misal;

  lsu_align u_align (
    .is_store (al_st),
    .funct3   (al_f3),
    .a        (al_a),
    .sdata    (store_data_in),
    .rdata    (dmem.dmem_rdata_in),
    .wmask    (al_wmask),
    .wdata    (al_wdata),
    .ldata    (al_ldata),
    .misal    (al_misal)
  );

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state: request, wait for grant, then data.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_valid_in) state_d = trap ? DONE : REQ;
      REQ:  if (dmem.dmem_gnt_in) state_d = is_store_q ? DONE : WAIT;
      WAIT: if (dmem.dmem_rvalid_in) state_d = WB;
      DONE: state_d = IDLE;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Op latch on accept; load result captured on rvalid.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      is_store_q <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= 4'b0000;
      rd_q       <= '0;
      misal_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (accept) begin
        is_store_q <= is_store_in;
        f3_q       <= funct3_in;
        addr_q     <= addr_n;
        wdata_q    <= al_wdata;
        wmask_q    <= is_store_in ? al_wmask : 4'b0000;
        rd_q       <= rd_addr_in;
        misal_q    <= trap;
      end
      if ((state_q == WAIT) && dmem.dmem_rvalid_in) begin
        rdata_q <= al_ldata;
      end
    end
  end

  assign req_ready_out       = idle;
  assign dmem.dmem_req_out   = (state_q == REQ);
  assign dmem.dmem_we_out    = (state_q == REQ) & is_store_q;
  assign dmem.dmem_addr_out  = {addr_q[XLEN-1:2], 2'b00};
  assign dmem.dmem_wdata_out = wdata_q;
  assign dmem.dmem_wmask_out = wmask_q;

  assign rd_addr_out  = rd_q;
  assign rd_data_out  = rdata_q;
  assign wr_en_out    = (state_q == WB) & (rd_q != '0);
  assign done_out     = (state_q == DONE) | (state_q == WB);
  assign misalign_out = TRAP_EN & misal_q & (state_q == DONE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed + random load/store ops against a
// byte-level reference model of the LSU.
module tb_load_store_unit;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        req_valid_in = 1'b0;
  logic        req_ready_out;
  logic        is_store_in = 1'b0;
  logic [2:0]  funct3_in = 3'b000;
  logic [31:0] base_in = '0;
  logic [31:0] offset_in = '0;
  logic [31:0] store_data_in = '0;
  logic [4:0]  rd_addr_in = '0;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_data_out;
  logic        wr_en_out;
  logic        done_out;
  logic        misalign_out;

  int checks = 0;
  int errors = 0;

  load_store_unit_if #(.XLEN(32)) dmem ();

  load_store_unit dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .is_store_in   (is_store_in),
    .funct3_in     (funct3_in),
    .base_in       (base_in),
    .offset_in     (offset_in),
    .store_data_in (store_data_in),
    .rd_addr_in    (rd_addr_in),
    .dmem          (dmem),
    .rd_addr_out   (rd_addr_out),
    .rd_data_out   (rd_data_out),
    .wr_en_out     (wr_en_out),
    .done_out      (done_out),
    .misalign_out  (misalign_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int msize(input bit st, input bit [2:0] f3);
    if (st) return (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
    if (f3 == 0 || f3 == 4) return 1;
    if (f3 == 1 || f3 == 5) return 2;
    return 4;
  endfunction

  task automatic run_op(input bit st, input bit [2:0] f3,
                        input logic [31:0] base, off, sd,
                        input logic [4:0] rd,
                        input int gw, rw,
                        input logic [31:0] word);
    logic [31:0] a, ea, exp_addr, exp_wd, exp_ld, v;
    logic [3:0]  exp_m;
    int sz, lo;
    bit uns, trap;
    a   = base + off;
    sz  = msize(st, f3);
    uns = !st && (f3 == 4 || f3 == 5);
    ea  = a & ~(32'(sz) - 32'd1);
    lo  = int'(ea % 4);
    exp_addr = ea - 32'(lo);
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = (a != ea);
`endif
    exp_m = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (st && i >= lo && i < lo + sz) exp_m[i] = 1'b1;
    for (int i = 0; i < 4; i++)
      exp_wd[8*i +: 8] = sd[8*(i % sz) +: 8];
    v = word >> (8 * lo);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end
    exp_ld = v;

    @(negedge clk_in);
    chk("ready_idle", req_ready_out, 1);
    req_valid_in  = 1'b1;
    is_store_in   = st;
    funct3_in     = f3;
    base_in       = base;
    offset_in     = off;
    store_data_in = sd;
    rd_addr_in    = rd;
    @(negedge clk_in);
    req_valid_in = 1'b0;
    if (trap) begin
      chk("trap_misalign", misalign_out, 1);
      chk("trap_done", done_out, 1);
      chk("trap_no_req", dmem.dmem_req_out, 0);
      chk("trap_no_wr", wr_en_out, 0);
      @(negedge clk_in);
      chk("trap_idle", req_ready_out, 1);
      chk("trap_flag_clr", misalign_out, 0);
      return;
    end
    chk("req", dmem.dmem_req_out, 1);
    chk("we", dmem.dmem_we_out, st);
    chk("addr", dmem.dmem_addr_out, exp_addr);
    chk("wmask", dmem.dmem_wmask_out, exp_m);
    if (st) chk("wdata", dmem.dmem_wdata_out, exp_wd);
    chk("no_misalign", misalign_out, 0);
    for (int i = 0; i < gw; i++) begin
      dmem.dmem_gnt_in    = 1'b0;
      dmem.dmem_rvalid_in = (i == 0);
      dmem.dmem_rdata_in  = $urandom;
      @(negedge clk_in);
      chk("req_hold", dmem.dmem_req_out, 1);
      chk("addr_hold", dmem.dmem_addr_out, exp_addr);
      chk("mask_hold", dmem.dmem_wmask_out, exp_m);
      chk("ready_busy", req_ready_out, 0);
    end
    dmem.dmem_rvalid_in = 1'b0;
    dmem.dmem_gnt_in    = 1'b1;
    @(negedge clk_in);
    dmem.dmem_gnt_in = 1'b0;
    if (st) begin
      chk("st_done", done_out, 1);
      chk("st_no_wr", wr_en_out, 0);
      chk("st_req_drop", dmem.dmem_req_out, 0);
      @(negedge clk_in);
      chk("st_done_clr", done_out, 0);
      chk("st_ready", req_ready_out, 1);
      return;
    end
    chk("ld_req_drop", dmem.dmem_req_out, 0);
    for (int i = 0; i < rw; i++) begin
      dmem.dmem_gnt_in = 1'b1;
      @(negedge clk_in);
      chk("wait_no_wr", wr_en_out, 0);
      chk("wait_no_done", done_out, 0);
    end
    dmem.dmem_gnt_in    = 1'b0;
    dmem.dmem_rvalid_in = 1'b1;
    dmem.dmem_rdata_in  = word;
    @(negedge clk_in);
    dmem.dmem_rvalid_in = 1'b0;
    chk("ld_wr_en", wr_en_out, (rd != 0));
    chk("ld_done", done_out, 1);
    chk("ld_rd_addr", rd_addr_out, rd);
    chk("ld_rd_data", rd_data_out, exp_ld);
    @(negedge clk_in);
    chk("ld_wr_clr", wr_en_out, 0);
    chk("ld_ready", req_ready_out, 1);
  endtask

  initial begin
    dmem.dmem_gnt_in    = 1'b0;
    dmem.dmem_rvalid_in = 1'b0;
    dmem.dmem_rdata_in  = '0;
    repeat (2) @(negedge clk_in);
    chk("rst_ready", req_ready_out, 1);
    chk("rst_req", dmem.dmem_req_out, 0);
    chk("rst_we", dmem.dmem_we_out, 0);
    chk("rst_addr", dmem.dmem_addr_out, 0);
    chk("rst_wdata", dmem.dmem_wdata_out, 0);
    chk("rst_wmask", dmem.dmem_wmask_out, 0);
    chk("rst_rd_data", rd_data_out, 0);
    chk("rst_wr_en", wr_en_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_misalign", misalign_out, 0);
    rst_in = 1'b1;

    // Stray grant while idle must not start anything.
    @(negedge clk_in);
    dmem.dmem_gnt_in = 1'b1;
    @(negedge clk_in);
    dmem.dmem_gnt_in = 1'b0;
    chk("idle_gnt_req", dmem.dmem_req_out, 0);
    chk("idle_gnt_ready", req_ready_out, 1);

    run_op(0, 3'b010, 32'h100, 32'h4, 0, 5'd5, 0, 0, 32'hDEADBEEF);
    run_op(0, 3'b000, 32'h100, 32'h3, 0, 5'd6, 0, 0, 32'h80FF_0000);
    run_op(0, 3'b100, 32'h100, 32'h3, 0, 5'd6, 0, 0, 32'h80FF_0000);
    run_op(1, 3'b000, 32'h200, 32'h2, 32'hA5, 5'd0, 0, 0, 0);
    run_op(0, 3'b010, 32'h180, 32'h0, 0, 5'd0, 3, 1, 32'h1234_5678);
    run_op(0, 3'b010, 32'h100, 32'h2, 0, 5'd9, 0, 0, 32'h1122_3344);
    run_op(1, 3'b001, 32'h300, 32'h2, 32'hCAFE_BEEF, 5'd1, 1, 0, 0);
    run_op(0, 3'b101, 32'h300, 32'h2, 0, 5'd2, 0, 2, 32'h8001_7FFF);
    run_op(0, 3'b001, 32'h300, 32'h2, 0, 5'd2, 0, 0, 32'h8001_7FFF);
    run_op(1, 3'b110, 32'hFFFF_FFFE, 32'h6, 32'h0BAD_F00D, 5'd3, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      run_op($urandom_range(0, 1), 3'($urandom_range(0, 7)),
             $urandom, 32'($urandom_range(0, 15)), $urandom,
             5'($urandom_range(0, 31)), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom);
    end

    // Async reset while request is pending drops it at once.
    @(negedge clk_in);
    req_valid_in = 1'b1;
    is_store_in  = 1'b0;
    funct3_in    = 3'b010;
    base_in      = 32'h400;
    offset_in    = 32'h0;
    rd_addr_in   = 5'd7;
    @(negedge clk_in);
    req_valid_in = 1'b0;
    chk("pre_rst_req", dmem.dmem_req_out, 1);
    rst_in = 1'b0;
    #1;
    chk("async_req_drop", dmem.dmem_req_out, 0);
    @(negedge clk_in);
    rst_in = 1'b1;

    // Reset in WAIT; a late rvalid afterwards is ignored.
    @(negedge clk_in);
    req_valid_in = 1'b1;
    @(negedge clk_in);
    req_valid_in = 1'b0;
    dmem.dmem_gnt_in = 1'b1;
    @(negedge clk_in);
    dmem.dmem_gnt_in = 1'b0;
    chk("wait_req_low", dmem.dmem_req_out, 0);
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    dmem.dmem_rvalid_in = 1'b1;
    dmem.dmem_rdata_in  = 32'hFFFF_FFFF;
    @(negedge clk_in);
    dmem.dmem_rvalid_in = 1'b0;
    chk("late_rv_wr", wr_en_out, 0);
    chk("late_rv_done", done_out, 0);
    chk("late_rv_ready", req_ready_out, 1);
    chk("late_rv_data", rd_data_out, 0);
    chk("late_rv_rd", rd_addr_out, 0);
    chk("late_rv_addr", dmem.dmem_addr_out, 0);
    chk("late_rv_req", dmem.dmem_req_out, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
